// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequencer: state encoding,
// default field widths, reset-time configuration values and the config record.
package pulse_seq_pkg;

  localparam int CNT_W_DEF    = 11;
  localparam int BURST_W_DEF  = 8;
  localparam int DEF_PERIOD   = 800;
  localparam int DEF_ON_START = 501;
  localparam int DEF_ON_STOP  = 801;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0]   period;
    logic [CNT_W_DEF-1:0]   on_start;
    logic [CNT_W_DEF-1:0]   on_stop;
    logic [BURST_W_DEF-1:0] bursts;
  } cfg_t;

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Configuration channel of the pulse sequencer.
// A transfer happens on every rising edge where cfg_valid and cfg_ready are
// both high; the fields are only meaningful while cfg_valid is high, and the
// master may drop or change an offer freely while cfg_ready is low.
interface pulse_seq_ctrl_if #(
  parameter int CNT_W   = 11,
  parameter int BURST_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_on_start;
  logic [CNT_W-1:0]   cfg_on_stop;
  logic [BURST_W-1:0] cfg_bursts;

  modport master (
    output cfg_valid, cfg_period, cfg_on_start, cfg_on_stop, cfg_bursts,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_on_start, cfg_on_stop, cfg_bursts,
    output cfg_ready
  );
endinterface

// File: rtl/pulse_frame_counter.sv
// Frame counter: counts 0..period while enabled, flags the wrap cycle and
// whether the current count lies inside the [on_start, on_stop) window.
module pulse_frame_counter #(
  parameter int CNT_W = 11
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             en,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on_start,
  input  logic [CNT_W-1:0] on_stop,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_window
);

  assign wrap      = (count == period);
  // An empty or inverted window (on_start >= on_stop) never matches.
  assign in_window = (count >= on_start) && (count < on_stop);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse sequencer controller: config registers, IDLE/RUN/DONE sequencing,
// burst counting and the registered PULSE output.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int BURST_W      = BURST_W_DEF,
  parameter int DEF_PERIOD   = pulse_seq_pkg::DEF_PERIOD,
  parameter int DEF_ON_START = pulse_seq_pkg::DEF_ON_START,
  parameter int DEF_ON_STOP  = pulse_seq_pkg::DEF_ON_STOP
) (
  input  logic               CLOCK,
  input  logic               RESET,
  pulse_seq_ctrl_if.slave    cfg_if,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] frame_idx,
  output logic               PULSE,
  output state_t             state_dbg
);

  state_t             state_q, state_d;
  cfg_t               cfg_q;
  logic [CNT_W-1:0]   count;
  logic               wrap, in_window;
  logic [BURST_W-1:0] frame_q;
  logic               pulse_q;
  logic               in_idle, in_run, cfg_load, run_start;
  logic               last_frame, final_wrap, cnt_clear;

  assign in_idle    = (state_q == IDLE);
  assign in_run     = (state_q == RUN);
  assign cfg_load   = in_idle && cfg_if.cfg_valid;
  assign run_start  = in_idle && start && !abort;
  // bursts==0 means continuous, so there is never a last frame.
  assign last_frame = (cfg_q.bursts != '0) && (frame_q == cfg_q.bursts - BURST_W'(1));
  assign final_wrap = wrap && last_frame;
  assign cnt_clear  = !in_run || abort;

  pulse_frame_counter #(.CNT_W(CNT_W)) u_frame_counter (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .en        (in_run),
    .clear     (cnt_clear),
    .period    (cfg_q.period),
    .on_start  (cfg_q.on_start),
    .on_stop   (cfg_q.on_stop),
    .count     (count),
    .wrap      (wrap),
    .in_window (in_window)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN: begin
        if (abort)           state_d = IDLE;
        else if (final_wrap) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_if.cfg_ready = (state_q == IDLE);
    busy             = (state_q == RUN);
    done             = (state_q == DONE);
  end

  // The config write and the run start share an edge, so a same-cycle
  // handshake and start run with the freshly loaded values.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cfg_q.period   <= CNT_W_DEF'(DEF_PERIOD);
      cfg_q.on_start <= CNT_W_DEF'(DEF_ON_START);
      cfg_q.on_stop  <= CNT_W_DEF'(DEF_ON_STOP);
      cfg_q.bursts   <= '0;
      frame_q        <= '0;
      pulse_q        <= 1'b0;
    end else begin
      if (cfg_load) begin
        cfg_q.period   <= cfg_if.cfg_period;
        cfg_q.on_start <= cfg_if.cfg_on_start;
        cfg_q.on_stop  <= cfg_if.cfg_on_stop;
        cfg_q.bursts   <= cfg_if.cfg_bursts;
      end
      if (run_start) begin
        frame_q <= '0;
      end else if (in_run && !abort && wrap && !last_frame) begin
        frame_q <= frame_q + BURST_W'(1);
      end
      pulse_q <= in_run && !abort && in_window;
    end
  end

  assign frame_idx = frame_q;
  assign PULSE     = pulse_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Bench for pulse_seq_ctrl: directed scenarios plus random traffic, all
// checked against a cycles-since-start arithmetic model of the sequencer.
module tb_pulse_seq_ctrl;
  import pulse_seq_pkg::*;

  localparam int CW = 11;
  localparam int BW = 8;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done, PULSE;
  logic [BW-1:0] frame_idx;
  state_t        state_dbg;

  pulse_seq_ctrl_if #(.CNT_W(CW), .BURST_W(BW)) cfg_if ();

  pulse_seq_ctrl #(.CNT_W(CW), .BURST_W(BW)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .cfg_if    (cfg_if),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .frame_idx (frame_idx),
    .PULSE     (PULSE),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK = ~CLOCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Position in a run is the number of RUN cycles elapsed (m_k); counter,
  // frame index and completion all follow from it by division.
  int m_period, m_on_start, m_on_stop, m_bursts;
  bit m_run, m_done, m_pulse;
  int m_k, m_frame;

  task automatic model_reset();
    m_period   = 800;
    m_on_start = 501;
    m_on_stop  = 801;
    m_bursts   = 0;
    m_run      = 0;
    m_done     = 0;
    m_pulse    = 0;
    m_k        = 0;
    m_frame    = 0;
  endtask

  task automatic model_step(input bit cv, input int per, input int ons, input int onf,
                            input int bur, input bit st, input bit ab);
    int  cnt;
    bit  win;
    logic [7:0] fr;
    if (m_run) begin
      cnt = m_k % (m_period + 1);
      win = (cnt >= m_on_start) && (cnt < m_on_stop);
      if (ab) begin
        m_run   = 0;
        m_pulse = 0;
      end else begin
        m_pulse = win;
        m_k++;
        if (m_bursts != 0 && m_k == m_bursts * (m_period + 1)) begin
          m_run   = 0;
          m_done  = 1;
          m_frame = m_bursts - 1;
        end else begin
          m_frame = (m_k / (m_period + 1)) % 256;
        end
      end
    end else if (m_done) begin
      m_done  = 0;
      m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (cv) begin
        m_period   = per;
        m_on_start = ons;
        m_on_stop  = onf;
        m_bursts   = bur;
      end
      if (st && !ab) begin
        m_run   = 1;
        m_k     = 0;
        m_frame = 0;
      end
    end
    fr = m_frame[7:0];
    exp_q.push_back({m_run, m_done, !m_run && !m_done, m_pulse, fr});
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit cv, input int per, input int ons, input int onf,
                     input int bur, input bit st, input bit ab);
    logic [11:0] e;
    @(negedge CLOCK);
    cfg_if.cfg_valid    = cv;
    cfg_if.cfg_period   = CW'(per);
    cfg_if.cfg_on_start = CW'(ons);
    cfg_if.cfg_on_stop  = CW'(onf);
    cfg_if.cfg_bursts   = BW'(bur);
    start               = st;
    abort               = ab;
    model_step(cv, per, ons, onf, bur, st, ab);
    @(posedge CLOCK);
    #1;
    e = exp_q.pop_front();
    check("busy",      busy,             e[11]);
    check("done",      done,             e[10]);
    check("cfg_ready", cfg_if.cfg_ready, e[9]);
    check("pulse",     PULSE,            e[8]);
    check("frame_idx", frame_idx,        e[7:0]);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  busy,             1'b0);
    check({tag, "_done"},  done,             1'b0);
    check({tag, "_ready"}, cfg_if.cfg_ready, 1'b1);
    check({tag, "_pulse"}, PULSE,            1'b0);
    check({tag, "_frame"}, frame_idx,        8'd0);
  endtask

  // ---------------- stimulus ----------------
  int pulse_cnt, n_wait;
  bit seen;

  initial begin
    cfg_if.cfg_valid    = 1'b0;
    cfg_if.cfg_period   = '0;
    cfg_if.cfg_on_start = '0;
    cfg_if.cfg_on_stop  = '0;
    cfg_if.cfg_bursts   = '0;
    model_reset();
    repeat (3) @(posedge CLOCK);
    #1;
    check_reset_outputs("reset");
    @(negedge CLOCK);
    RESET = 1'b0;

    // Reset defaults: continuous run, 300 pulse cycles per 801-cycle frame.
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("default_busy", busy, 1'b1);
    pulse_cnt = 0;
    for (int i = 0; i < 801; i++) begin
      idle_cyc();
      pulse_cnt += int'(PULSE);
    end
    check("default_pulse_count", pulse_cnt, 300);
    for (int i = 0; i < 900; i++) idle_cyc();
    check("default_frame1", frame_idx, 8'd2);
    cyc(0, 0, 0, 0, 0, 0, 1);

    // Burst of 3: done 30 cycles after RUN entry, 9 pulse cycles overall.
    cyc(1, 9, 2, 5, 3, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    n_wait = 0; pulse_cnt = 0; seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      idle_cyc();
      pulse_cnt += int'(PULSE);
      n_wait = i;
      seen = done;
    end
    check("burst3_done_seen", seen, 1'b1);
    check("burst3_done_delay", n_wait, 30);
    check("burst3_pulse_count", pulse_cnt, 9);
    idle_cyc();
    check("burst3_ready_after", cfg_if.cfg_ready, 1'b1);

    // Abort mid-frame at counter 3 (inside the window).
    cyc(1, 9, 2, 5, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (3) idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("abort_pulse", PULSE, 1'b0);
    check("abort_busy", busy, 1'b0);
    idle_cyc();

    // Handshake and start together: run uses period 4, two bursts.
    cyc(1, 4, 1, 3, 2, 1, 0);
    n_wait = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      idle_cyc();
      n_wait = i;
      seen = done;
    end
    check("simul_done_delay", n_wait, 10);

    // Abort on the final-wrap cycle of a 2-burst run: no done.
    idle_cyc();
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (9) idle_cyc();
    cyc(0, 0, 0, 0, 0, 0, 1);
    check("final_abort_done", done, 1'b0);
    idle_cyc();
    check("final_abort_done_next", done, 1'b0);

    // Degenerate: period 0, empty window, one burst.
    cyc(1, 0, 6, 6, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check("degen_busy", busy, 1'b1);
    idle_cyc();
    check("degen_done", done, 1'b1);
    check("degen_pulse", PULSE, 1'b0);
    idle_cyc();

    // Config offered during RUN must be ignored (following run keeps period 9).
    cyc(1, 9, 2, 5, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 3, 0, 3, 0, 0, 0);
    check("run_cfg_ready", cfg_if.cfg_ready, 1'b0);
    repeat (12) idle_cyc();
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (12) idle_cyc();

    // Asynchronous reset mid-run.
    cyc(0, 0, 0, 0, 0, 1, 0);
    repeat (4) idle_cyc();
    @(negedge CLOCK);
    #1;
    RESET = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge CLOCK);
    RESET = 1'b0;

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      cyc($urandom_range(0, 3) == 0,
          int'($urandom_range(0, 12)),
          int'($urandom_range(0, 14)),
          int'($urandom_range(0, 14)),
          int'($urandom_range(0, 4)),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
